uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx transmitter between NUM_REQ byte requesters, round-robin.
//  Each requester holds a request and data until acked. The arbiter issues one
//  write pulse per byte to uart_tx. It then tracks uart_tx busy through the full
//  frame before granting again, and flags a transmitter that never goes busy.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  DATA_BITS    8   byte width, must match uart_tx
//  BUSY_TIMEOUT 3   cycles to wait for i_tx_busy rise after a write pulse
// PORTS
//  i_clk        in   1                 system clock; only clock
//  i_reset      in   1                 synchronous, active-high reset
//  i_req        in   NUM_REQ           per-requester request, held until o_ack
//  i_data       in   NUM_REQ*DATA_BITS requester k byte at [k*DATA_BITS +: DATA_BITS]
//  o_ack        out  NUM_REQ           one-cycle pulse: requester's byte latched
//  o_grant      out  NUM_REQ           one-hot owner of current frame, 0 when idle
//  o_tx_data    out  DATA_BITS         to uart_tx i_data
//  o_tx_write   out  1                 to uart_tx i_write, one-cycle pulse
//  i_tx_busy    in   1                 from uart_tx o_busy
//  o_busy       out  1                 high in any state except ST_IDLE
//  o_err        out  1                 one-cycle pulse on busy timeout
//  o_byte_count out  16                frames completed, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: every output is 0. The state goes to ST_IDLE. The RR pointer is set to
//   NUM_REQ-1, so requester 0 wins first. Reset mid-frame abandons the frame
//   with no ack or err.
//  States:
//   ST_IDLE:
//    - Arbitrates only when i_tx_busy==0 and |i_req.
//    - Search starts at pointer+1 mod NUM_REQ; the first requester with req set wins.
//    - On the winning edge: latch its byte into o_tx_data and set o_grant.
//    - Next cycle: o_tx_write=1 and o_ack[k]=1, both for one cycle only.
//    - Pointer <= k. State goes to ST_WAIT_BUSY.
//   ST_WAIT_BUSY:
//    - i_tx_busy==1 -> ST_WAIT_DONE.
//    - uart_tx raises busy one cycle after the write.
//    - Counter reaches BUSY_TIMEOUT with no busy: o_err pulses, o_grant clears,
//      state -> ST_IDLE, byte count unchanged.
//   ST_WAIT_DONE:
//    - i_tx_busy==0 -> o_byte_count+1, o_grant clears, state -> ST_IDLE.
//  Latency: req seen in IDLE -> write/ack on edge+1 -> next grant no earlier
//   than 1 cycle after busy falls.
//  Requester drops req before ack: it is not served; no ack, no error.
//  Requester held in req across grants: served again only after all other
//   active requesters are served (fairness).
//  i_tx_busy high while in ST_IDLE (e.g. after reset mid-frame): no grant until
//   it falls.
//  o_tx_data is stable from the write pulse until the next grant.
// CONFIGURATION
//  Macro UART_TX_ARB_LOCK_EN:
//   Defined:
//    - Adds input i_lock [NUM_REQ], sampled with the winning request.
//    - If the owner had i_lock set and still has i_req high on return to
//      ST_IDLE, it is re-granted ahead of RR (multi-byte message atomicity).
//    - Lock ends when the owner's i_req or i_lock is low at that point.
//    - The pointer still updates to the owner.
//    - A timeout also clears the lock.
//   Undefined: no i_lock port; pure per-byte round-robin.
// TESTING
//  1 Reset, with uart_tx model busy for 10 cycles per frame:
//    - req=0001, data0=0xA5 -> o_tx_write and o_ack=0001 one cycle later.
//    - o_tx_data=0xA5; o_byte_count=1 after busy falls.
//  2 req=1111 held, data k=0x10+k:
//    - Acks and data in order 0,1,2,3,0, i.e. 0x10,0x11,0x12,0x13,0x10.
//    - Exactly one write per frame.
//  3 i_tx_busy tied 0:
//    - After a write, o_err pulses BUSY_TIMEOUT cycles later.
//    - State back to idle, o_byte_count unchanged, next requester served.
//  4 Assert i_reset mid WAIT_DONE with busy still high:
//    - All outputs 0 next cycle.
//    - No write while busy high; requester 0 granted once busy falls.
//  5 UART_TX_ARB_LOCK_EN, req=0011, lock=0010, req1 held for 3 bytes:
//    - Grant order 0,1,1,1,0.
//    - Without the macro: 0,1,0,1.
//  6 Preload o_byte_count to 0xFFFF, complete one frame -> 0x0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// Optional owner lock for multi-byte messages: define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned BUSY_TIMEOUT = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           i_lock,
`endif
  output logic [NUM_REQ-1:0]           o_ack,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [DATA_BITS-1:0]         o_tx_data,
  output logic                         o_tx_write,
  input  logic                         i_tx_busy,
  output logic                         o_busy,
  output logic                         o_err,
  output logic [15:0]                  o_byte_count
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [DATA_BITS-1:0]   txd_q, txd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            byte_cnt_q, byte_cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
  logic                   lock_q, lock_d;
`endif

  logic                   rr_found;
  logic [PW-1:0]          rr_idx;
  logic [PW-1:0]          win_idx;
  logic [NUM_REQ-1:0]     win_vec;

  // Search begins one past the last owner so every active requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      logic [PW-1:0] j;
      j = PW'((32'(ptr_q) + i) % NUM_REQ);
      if (!rr_found && i_req[j]) begin
        rr_found = 1'b1;
        rr_idx   = j;
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  assign win_idx = (lock_q && i_req[ptr_q]) ? ptr_q : rr_idx;
`else
  assign win_idx = rr_idx;
`endif
  assign win_vec = NUM_REQ'(1) << win_idx;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    write_d    = 1'b0;
    err_d      = 1'b0;
    txd_d      = txd_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef UART_TX_ARB_LOCK_EN
        if (!i_req[ptr_q]) lock_d = 1'b0;
`endif
        if (!i_tx_busy && rr_found) begin
          txd_d   = i_data[win_idx*DATA_BITS +: DATA_BITS];
          grant_d = win_vec;
          ack_d   = win_vec;
          write_d = 1'b1;
          ptr_d   = win_idx;
          state_d = ST_WAIT_BUSY;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d  = i_lock[win_idx];
`endif
        end
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          grant_d    = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PW'(NUM_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      txd_q      <= '0;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      write_q    <= write_d;
      err_q      <= err_d;
      txd_q      <= txd_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign o_ack        = ack_q;
  assign o_grant      = grant_q;
  assign o_tx_data    = txd_q;
  assign o_tx_write   = write_q;
  assign o_err        = err_q;
  assign o_byte_count = byte_cnt_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
